// File: rtl/button_pkg.sv
// Shared types and constants for the push-button conditioning path.
package button_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOCK,
    WAIT_RELEASE
  } state_t;

  localparam int BTN_ID_W = 2;

  localparam logic [BTN_ID_W-1:0] BTN_NORTH = 2'd0;
  localparam logic [BTN_ID_W-1:0] BTN_EAST  = 2'd1;
  localparam logic [BTN_ID_W-1:0] BTN_SOUTH = 2'd2;
  localparam logic [BTN_ID_W-1:0] BTN_WEST  = 2'd3;

  // Fixed-priority pick among simultaneous press events: north wins, west loses.
  function automatic logic [BTN_ID_W-1:0] first_press(input logic [3:0] ev);
    logic [BTN_ID_W-1:0] id;
    id = BTN_NORTH;
    if (ev[0])      id = BTN_NORTH;
    else if (ev[1]) id = BTN_EAST;
    else if (ev[2]) id = BTN_SOUTH;
    else if (ev[3]) id = BTN_WEST;
    return id;
  endfunction

endpackage

// File: rtl/button_conditioner_debounce.sv
// One-button conditioner: two-flop synchroniser, persistence debouncer and
// press (rising edge of the debounced level) flag.
module debounce_cell #(
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CNT_W = $clog2(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  logic             sync1_reg;
  logic             sync2_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             stable_reg;
  logic             stable_d_reg;

  // Bring the asynchronous pin into the clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
    end else begin
      sync1_reg <= raw;
      sync2_reg <= sync1_reg;
    end
  end

  // Accept a new level only after it has differed for DB_CYCLES consecutive
  // cycles; any bounce back to the stable level restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg    <= '0;
      stable_reg <= 1'b0;
    end else if (sync2_reg == stable_reg) begin
      cnt_reg <= '0;
    end else if (cnt_reg == CNT_MAX) begin
      stable_reg <= sync2_reg;
      cnt_reg    <= '0;
    end else begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  // Delayed copy of the stable level so the press flag comes from registers only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stable_d_reg <= 1'b0;
    else        stable_d_reg <= stable_reg;
  end

  assign level = stable_reg;
  assign rise  = stable_reg & ~stable_d_reg;

endmodule

// File: rtl/button_conditioner.sv
// Four-button conditioner: per-button debounce, fixed-priority arbitration and
// a lockout / wait-for-release FSM producing a single clean guess strobe.
module button_conditioner
  import button_pkg::*;
#(
  parameter int DB_CYCLES      = 1_000_000,
  parameter int LOCKOUT_CYCLES = 12_500_000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                btn_north,
  input  logic                btn_east,
  input  logic                btn_south,
  input  logic                btn_west,
  output logic                btn_out,
  output logic [BTN_ID_W-1:0] btn_id,
  output logic [3:0]          btn_level,
  output logic                busy
);

  localparam int LK_W = $clog2(LOCKOUT_CYCLES + 1);
  localparam logic [LK_W-1:0] LK_LOAD = LK_W'(LOCKOUT_CYCLES - 1);

  logic [3:0] raw_vec;
  logic [3:0] level_vec;
  logic [3:0] rise_vec;

  assign raw_vec = {btn_west, btn_south, btn_east, btn_north};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : gen_cell
      debounce_cell #(
        .DB_CYCLES(DB_CYCLES)
      ) u_cell (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (raw_vec[gi]),
        .level (level_vec[gi]),
        .rise  (rise_vec[gi])
      );
    end
  endgenerate

  state_t              state_reg, state_next;
  logic [LK_W-1:0]     lock_cnt_reg, lock_cnt_next;
  logic                btn_out_reg, btn_out_next;
  logic [BTN_ID_W-1:0] btn_id_reg, btn_id_next;
  logic                busy_reg;

  // Next-state and output decode: accept one press, hold off, then wait for all
  // buttons to be released before accepting again.
  always_comb begin
    state_next    = state_reg;
    lock_cnt_next = lock_cnt_reg;
    btn_out_next  = 1'b0;
    btn_id_next   = btn_id_reg;
    case (state_reg)
      IDLE: begin
        if (|rise_vec) begin
          btn_out_next  = 1'b1;
          btn_id_next   = first_press(rise_vec);
          lock_cnt_next = LK_LOAD;
          state_next    = LOCK;
        end
      end
      LOCK: begin
        if (lock_cnt_reg == '0) state_next = WAIT_RELEASE;
        else                    lock_cnt_next = lock_cnt_reg - LK_W'(1);
      end
      WAIT_RELEASE: begin
        if (level_vec == 4'b0000) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State, lockout counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      lock_cnt_reg <= '0;
      btn_out_reg  <= 1'b0;
      btn_id_reg   <= BTN_NORTH;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      lock_cnt_reg <= lock_cnt_next;
      btn_out_reg  <= btn_out_next;
      btn_id_reg   <= btn_id_next;
      busy_reg     <= (state_next != IDLE);
    end
  end

  assign btn_out   = btn_out_reg;
  assign btn_id    = btn_id_reg;
  assign btn_level = level_vec;
  assign busy      = busy_reg;

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: directed scenarios plus random
// button activity, compared every cycle against a behavioural model.
module tb_button_conditioner;

  localparam int DB = 8;
  localparam int LK = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       bn = 1'b0, be = 1'b0, bs = 1'b0, bw = 1'b0;
  logic       btn_out;
  logic [1:0] btn_id;
  logic [3:0] btn_level;
  logic       busy;

  always #5 clk = ~clk;

  button_conditioner #(
    .DB_CYCLES(DB),
    .LOCKOUT_CYCLES(LK)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_north (bn),
    .btn_east  (be),
    .btn_south (bs),
    .btn_west  (bw),
    .btn_out   (btn_out),
    .btn_id    (btn_id),
    .btn_level (btn_level),
    .busy      (busy)
  );

  int errors = 0;
  int checks = 0;
  int edge_n = 0;
  int pulses = 0;
  int first_pulse = -1;
  int last_pulse = -1;
  logic [1:0] pulse_id = 2'd0;
  logic [3:0] level_seen = 4'b0;

  // Behavioural model: raw samples delayed two edges, a level is accepted when
  // the last DB synchronised samples all disagree with it; presses are level
  // rises seen one edge later; after an accepted press everything is ignored
  // for LK edges and until all levels read zero.
  logic [1:0] pipe [4];
  bit         sq [4][$];
  logic [3:0] lvl_a, lvl_b;
  bit         engaged;
  int         acc_edge;
  logic       exp_out;
  logic [1:0] exp_id;
  logic       exp_busy;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s edge=%0d observed=%0h expected=%0h", tag, edge_n, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      pipe[i] = 2'b00;
      sq[i].delete();
    end
    lvl_a = 4'b0; lvl_b = 4'b0;
    engaged = 1'b0; acc_edge = 0;
    exp_out = 1'b0; exp_id = 2'd0; exp_busy = 1'b0;
  endtask

  task automatic model_edge(input logic [3:0] raw);
    logic [3:0] rise, nxt;
    bit all_diff;
    rise = lvl_a & ~lvl_b;
    exp_out = 1'b0;
    if (engaged) begin
      if (edge_n > acc_edge + LK && lvl_a == 4'b0) engaged = 1'b0;
    end else if (rise != 4'b0) begin
      exp_out = 1'b1;
      engaged = 1'b1;
      acc_edge = edge_n;
      for (int i = 3; i >= 0; i--) if (rise[i]) exp_id = 2'(i);
    end
    exp_busy = engaged;
    nxt = lvl_a;
    for (int i = 0; i < 4; i++) begin
      sq[i].push_back(pipe[i][1]);
      pipe[i] = {pipe[i][0], raw[i]};
      if (sq[i].size() > DB) void'(sq[i].pop_front());
      if (sq[i].size() == DB) begin
        all_diff = 1'b1;
        for (int j = 0; j < sq[i].size(); j++) if (sq[i][j] == lvl_a[i]) all_diff = 1'b0;
        if (all_diff) nxt[i] = ~lvl_a[i];
      end
    end
    lvl_b = lvl_a;
    lvl_a = nxt;
  endtask

  task automatic set_btn(input logic [3:0] v);
    {bw, bs, be, bn} = v;
  endtask

  task automatic tick();
    logic [3:0] raw;
    raw = {bw, bs, be, bn};
    @(posedge clk);
    edge_n++;
    model_edge(raw);
    #1;
    check("btn_out", {3'b0, btn_out}, {3'b0, exp_out});
    check("btn_id", {2'b0, btn_id}, {2'b0, exp_id});
    check("btn_level", btn_level, lvl_a);
    check("busy", {3'b0, busy}, {3'b0, exp_busy});
    if (btn_out === 1'b1) begin
      pulses++;
      if (first_pulse < 0) first_pulse = edge_n;
      last_pulse = edge_n;
      pulse_id = btn_id;
    end
    level_seen |= btn_level;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  // Asynchronous reset: outputs must clear without waiting for a clock edge.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_btn_out", {3'b0, btn_out}, 4'h0);
    check("rst_btn_id", {2'b0, btn_id}, 4'h0);
    check("rst_btn_level", btn_level, 4'h0);
    check("rst_busy", {3'b0, busy}, 4'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    edge_n = 0;
    pulses = 0;
    first_pulse = -1;
    last_pulse = -1;
    level_seen = 4'b0;
  endtask

  int rem [4];
  logic [3:0] rval;

  initial begin
    model_reset();

    // Clean north press sampled at edge 10, held 40 cycles.
    set_btn(4'b0000);
    do_reset();
    ticks(9);
    set_btn(4'b0001);
    ticks(40);
    set_btn(4'b0000);
    ticks(30);
    check_int("north_pulses", pulses, 1);
    check_int("north_pulse_edge", last_pulse, 20);
    check_int("north_id", int'(pulse_id), 0);
    $display("north press: pulses=%0d edge=%0d", pulses, last_pulse);

    // East bouncing every 3 cycles for 20 cycles, then held; last rise at edge 19.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      set_btn({2'b00, ((i / 3) % 2 == 0), 1'b0});
      tick();
    end
    set_btn(4'b0010);
    ticks(40);
    set_btn(4'b0000);
    ticks(30);
    check_int("east_pulses", pulses, 1);
    check_int("east_pulse_edge", last_pulse, 29);
    check_int("east_id", int'(pulse_id), 1);
    $display("east bounce: pulses=%0d edge=%0d", pulses, last_pulse);

    // South glitch one cycle shorter than the debounce window.
    do_reset();
    ticks(2);
    set_btn(4'b0100);
    ticks(7);
    set_btn(4'b0000);
    ticks(20);
    check("glitch_level_seen", level_seen, 4'b0000);
    check_int("glitch_pulses", pulses, 0);
    $display("south glitch: level_seen=%0h pulses=%0d", level_seen, pulses);

    // South and west together; busy until both released after lockout.
    do_reset();
    set_btn(4'b1100);
    ticks(30);
    set_btn(4'b1000);
    ticks(20);
    check("dual_busy_west_held", {3'b0, busy}, 4'h1);
    check("dual_level_west_only", btn_level, 4'b1000);
    set_btn(4'b0000);
    ticks(20);
    check("dual_busy_released", {3'b0, busy}, 4'h0);
    check_int("dual_pulses", pulses, 1);
    check_int("dual_id", int'(pulse_id), 2);
    $display("south+west: pulses=%0d id=%0d", pulses, pulse_id);

    // West re-pressed during lockout (ignored), then after release (accepted).
    do_reset();
    set_btn(4'b1000);
    ticks(8);
    set_btn(4'b0000);
    ticks(8);
    set_btn(4'b1000);
    ticks(24);
    set_btn(4'b0000);
    ticks(15);
    set_btn(4'b1000);
    ticks(20);
    set_btn(4'b0000);
    ticks(30);
    check_int("west_pulses", pulses, 2);
    check_int("west_first_edge", first_pulse, 11);
    check_int("west_second_edge", last_pulse, 66);
    $display("west repeat: pulses=%0d first=%0d second=%0d", pulses, first_pulse, last_pulse);

    // Reset while in lockout with north held; the held button is re-debounced.
    do_reset();
    set_btn(4'b0001);
    ticks(20);
    check("lock_busy_before_reset", {3'b0, busy}, 4'h1);
    do_reset();
    ticks(30);
    check_int("reset_pulses", pulses, 1);
    check_int("reset_pulse_edge", last_pulse, 11);
    check_int("reset_id", int'(pulse_id), 0);
    set_btn(4'b0000);
    ticks(30);
    $display("reset in lock: pulses=%0d edge=%0d", pulses, last_pulse);

    // Random button activity with short bounces and long holds, one mid-run reset.
    do_reset();
    rval = 4'b0;
    for (int i = 0; i < 4; i++) rem[i] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < 4; i++) begin
        if (rem[i] == 0) begin
          rval[i] = ~rval[i];
          rem[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 9)) : int'($urandom_range(10, 50));
        end
        rem[i]--;
      end
      set_btn(rval);
      if (cyc == 1500) do_reset();
      tick();
    end
    set_btn(4'b0000);
    ticks(60);
    check("random_final_busy", {3'b0, busy}, 4'h0);
    $display("random run: pulses since last reset=%0d", pulses);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
